// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch/decode-side signals of the IF/ID fetch queue.
// Fetch drives ValidF/InstrF/PCPlus4F and reads FullF.
// Hazard logic drives CLR/StallD.
// Decode reads InstrD/PCPlus4D/ValidD, and CountQ exposes the queue occupancy.
interface if_id_queue_if #(parameter int DATA_W = 32, parameter int DEPTH = 4);
  logic                       CLR;
  logic                       StallD;
  logic                       ValidF;
  logic [DATA_W-1:0]          InstrF;
  logic [DATA_W-1:0]          PCPlus4F;
  logic                       FullF;
  logic [$clog2(DEPTH+1)-1:0] CountQ;
  logic [DATA_W-1:0]          InstrD;
  logic [DATA_W-1:0]          PCPlus4D;
  logic                       ValidD;
  modport master (output CLR, StallD, ValidF, InstrF, PCPlus4F,
                  input FullF, CountQ, InstrD, PCPlus4D, ValidD);
  modport slave (input CLR, StallD, ValidF, InstrF, PCPlus4F,
                 output FullF, CountQ, InstrD, PCPlus4D, ValidD);
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry fetch queue feeding a valid-tagged IF/ID decode register.
// Ports:
//   clk, rst - clock and synchronous active-high reset.
//   q        - if_id_queue_if slave modport, which carries the flush, stall and fetch entry inputs,
//              plus FullF, CountQ and the decode register outputs.
// Define IFID_BYPASS_EN to let a fetch entry go straight into the decode register when the queue is empty.
module if_id_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic [DATA_W-1:0]   instr_d, pc_d;
  logic                valid_d, push, pop, byp, wr;
  assign q.FullF    = count == CW'(DEPTH);
  assign q.CountQ   = count;
  assign q.InstrD   = instr_d;
  assign q.PCPlus4D = pc_d;
  assign q.ValidD   = valid_d;
  assign push = q.ValidF & ~q.FullF;
  assign pop  = ~q.StallD & (count != '0);
`ifdef IFID_BYPASS_EN
  assign byp = push & ~q.StallD & (count == '0);
`else
  assign byp = 1'b0;
`endif
  // A bypassed entry skips the array entirely.
  assign wr = push & ~byp;
  always_ff @(posedge clk)
    if (wr && !rst && !q.CLR) mem[wr_ptr] <= {q.InstrF, q.PCPlus4F};
  always_ff @(posedge clk) begin
    if (rst || q.CLR) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      instr_d <= '0;
      pc_d    <= '0;
      valid_d <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
      if (!q.StallD) begin
        {instr_d, pc_d} <= pop ? mem[rd_ptr] : byp ? {q.InstrF, q.PCPlus4F} : '0;
        valid_d         <= pop | byp;
      end
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed and random stimulus for if_id_queue, checked against a scoreboard and an occupancy model.
module tb_if_id_queue;
  localparam int DW = 32;
  localparam int DEPTH = 4;
`ifdef IFID_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  int mc = 0;
  logic [2*DW-1:0] sb[$];
  if_id_queue_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
  if_id_queue #(.DATA_W(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit full_pre, acc, byp, pop, adv, clr;
    logic [2*DW:0] held;
    logic [2*DW-1:0] e;
    full_pre = (mc == DEPTH);
    clr = rst | bus.CLR;
    acc = bus.ValidF & ~full_pre & ~clr;
    byp = BYP & acc & ~bus.StallD & (mc == 0);
    pop = ~bus.StallD & (mc != 0) & ~clr;
    adv = ~bus.StallD & ~clr;
    held = {bus.InstrD, bus.PCPlus4D, bus.ValidD};
    if (clr) begin
      mc = 0;
      sb.delete();
    end else begin
      if (acc) sb.push_back({bus.InstrF, bus.PCPlus4F});
      mc = mc + int'(acc & ~byp) - int'(pop);
    end
    @(posedge clk);
    #1;
    chk("CountQ", 64'(bus.CountQ), 64'(mc));
    chk("FullF", 64'(bus.FullF), 64'(mc == DEPTH));
    if (clr) begin
      chk("clr_ValidD", 64'(bus.ValidD), 64'd0);
      chk("clr_InstrD", 64'(bus.InstrD), 64'd0);
      chk("clr_PCPlus4D", 64'(bus.PCPlus4D), 64'd0);
    end else if (adv) begin
      if (pop || byp) begin
        chk("ValidD", 64'(bus.ValidD), 64'd1);
        if (sb.size() == 0) chk("sb_underrun", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("InstrD", 64'(bus.InstrD), 64'(e[2*DW-1:DW]));
          chk("PCPlus4D", 64'(bus.PCPlus4D), 64'(e[DW-1:0]));
        end
      end else begin
        chk("bubble_ValidD", 64'(bus.ValidD), 64'd0);
        chk("bubble_InstrD", 64'(bus.InstrD), 64'd0);
      end
    end else begin
      chk("stall_hold", 64'({bus.InstrD, bus.PCPlus4D, bus.ValidD}), 64'(held));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.CLR = 1'b0;
    bus.StallD = 1'b0;
    bus.ValidF = 1'b1;
    bus.InstrF = 32'h2008_0005;
    bus.PCPlus4F = 32'h4;
    tick();
    tick();
    chk("reset_ValidD", 64'(bus.ValidD), 64'd0);
    chk("reset_CountQ", 64'(bus.CountQ), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.ValidF = 1'b1;
      bus.InstrF = 32'h11 + 32'(i);
      bus.PCPlus4F = 32'(4 * (i + 1));
      tick();
      if (i == 0) chk("first_latency_ValidD", 64'(bus.ValidD), 64'(BYP));
    end
    chk("stream_CountQ", 64'(bus.CountQ), 64'(!BYP));
    bus.ValidF = 1'b0;
    tick();
    tick();
    bus.StallD = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.ValidF = 1'b1;
      bus.InstrF = 32'h21 + 32'(i);
      bus.PCPlus4F = 32'h40 + 32'(4 * i);
      tick();
    end
    chk("fill_CountQ", 64'(bus.CountQ), 64'd4);
    chk("fill_FullF", 64'(bus.FullF), 64'd1);
    bus.StallD = 1'b0;
    bus.InstrF = 32'h99;
    tick();
    chk("fullpop_CountQ", 64'(bus.CountQ), 64'd3);
    chk("fullpop_FullF", 64'(bus.FullF), 64'd0);
    bus.StallD = 1'b1;
    bus.CLR = 1'b1;
    bus.InstrF = 32'h55;
    tick();
    bus.CLR = 1'b0;
    bus.StallD = 1'b0;
    bus.InstrF = 32'hAB;
    bus.PCPlus4F = 32'h100;
    tick();
    bus.ValidF = 1'b0;
    if (!BYP) tick();
    chk("flush_next_InstrD", 64'(bus.InstrD), 64'hAB);
    for (int i = 0; i < 3; i++) tick();
    chk("empty_CountQ", 64'(bus.CountQ), 64'd0);
    for (int i = 0; i < 300; i++) begin
      bus.ValidF = 1'($urandom_range(0, 3) != 0);
      bus.StallD = 1'($urandom_range(0, 2) == 0);
      bus.CLR = 1'($urandom_range(0, 40) == 0);
      bus.InstrF = $urandom;
      bus.PCPlus4F = $urandom;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF/ID boundary for the pipelined MIPS CPU: a DEPTH-entry fetch queue between the fetch stage and the decode-stage register. Fetch pushes instruction/PC+4 pairs whenever the queue has room. Decode pops one entry per cycle unless stalled. Flush (branch taken / PCSrc) empties everything and inserts a bubble. A valid bit travels with every decode-stage entry, so bubbles are explicit rather than encoded as instruction 0.

## Interface
- DATA_W, 32: width of instruction and PC+4 fields.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- CLR  in  1  flush (PCSrc); clears queue and decode register.
- StallD  in  1  decode stall; hold decode outputs, no pop.
- ValidF  in  1  fetch presents an entry this cycle.
- InstrF  in  DATA_W  fetched instruction.
- PCPlus4F  in  DATA_W  fetch PC+4.
- FullF  out  1  combinational; count==DEPTH; fetch must hold PC while high.
- CountQ  out  $clog2(DEPTH+1)  registered queue occupancy.
- InstrD  out  DATA_W  decode-stage instruction (registered).
- PCPlus4D  out  DATA_W  decode-stage PC+4 (registered).
- ValidD  out  1  decode-stage entry is real (0 = bubble).

## Operation
- Storage: DEPTH×(2·DATA_W) array, rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrap modulo DEPTH, count 0..DEPTH.
- Priority per edge: rst > CLR > normal.
- rst or CLR: count=0, rd_ptr=wr_ptr=0, InstrD=0, PCPlus4D=0, ValidD=0. Any concurrent push is dropped. Array contents are don't-care.
- push = ValidF & ~FullF. FullF is evaluated on pre-edge count, so a push at full is rejected even if a pop occurs the same cycle.
- pop = ~StallD & (count≠0).
- StallD=1: InstrD/PCPlus4D/ValidD hold. A push still proceeds if not full.
- StallD=0, count≠0: decode register loads head entry, ValidD=1, rd_ptr++.
- StallD=0, count=0: see Configuration. Without a bypass, decode register loads 0/0, ValidD=0 (bubble).
- count_next = count + push − pop. Simultaneous push/pop leaves count unchanged. The count must never exceed DEPTH or underflow.
- Order strictly FIFO; no entry duplicated or lost except by flush.

## Timing
- All outputs except FullF are registered.
- FullF is a pure function of the count register (no input-to-output path).
- Latency, no bypass: entry pushed at edge N appears on InstrD at edge N+1 at earliest (queue empty, StallD low).
- Throughput: one entry per cycle sustained with StallD low and ValidF high. Count stays at 0 with the bypass, or at 1 without it.
- Decode stalled for K cycles with fetch streaming: queue fills, and FullF asserts after DEPTH pushes.
- CLR asserted at edge N: ValidD=0 after N. The first post-flush push is accepted in the cycle after N.

## Configuration
- IFID_BYPASS_EN defined: when count==0, StallD=0 and push=1, the fetch entry loads directly into the decode register (ValidD=1) at the same edge. The queue is not written and the count stays 0. Fetch-to-decode latency is 1 cycle, matching the single-register IF/ID.
- IFID_BYPASS_EN undefined: no bypass; every entry passes through the queue, and fetch-to-decode latency is 2 edges.

## Test plan
- Reset: hold rst 2 cycles with ValidF=1, InstrF=0x20080005 -> ValidD=0, InstrD=0, PCPlus4D=0, CountQ=0, FullF=0.
- Stream: push 0x11..0x18 with PCPlus4F 4,8,..,32, StallD=0 -> InstrD sequence 0x11..0x18 in order, ValidD=1 each cycle. First appears 1 edge after push with IFID_BYPASS_EN, 2 edges without.
- Fill: StallD=1 and push 6 entries with DEPTH=4 -> FullF=1 after 4 pushes, entries 5–6 rejected, CountQ=4, InstrD held.
- Full plus simultaneous pop: at count=4, set StallD=0 with ValidF=1 -> head popped, push rejected, CountQ=3, FullF=0 next cycle.
- Flush: with count=3 and StallD=1, assert CLR together with ValidF=1 -> next edge CountQ=0, ValidD=0, InstrD=0. The next pushed entry, 0xAB, is the next valid InstrD.
- Empty pop: no pushes, StallD=0 for 3 cycles -> ValidD=0, InstrD=0. CountQ stays 0 with no underflow.
